// File: rtl/mux_uart_pkg.sv
// Shared constants and state encodings for the mux_uart bus-attached serial port.
package mux_uart_pkg;

   // Status register bit positions
   localparam int unsigned StRxRdy  = 0;
   localparam int unsigned StTxRdy  = 1;
   localparam int unsigned StOvr    = 2;
   localparam int unsigned StFe     = 3;
   localparam int unsigned StTxIdle = 4;

   // Register offsets from BASE_ADDR
   localparam logic [1:0] OffStatus = 2'd0;
   localparam logic [1:0] OffData   = 2'd1;
   localparam logic [1:0] OffIrqEn  = 2'd2;

   localparam logic [3:0] IrqLevel = 4'd6;

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

endpackage

// File: rtl/mux_uart_fifo.sv
// 8-bit synchronous FIFO; a pop frees its slot for a same-cycle push even when full.
module mux_uart_fifo
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   import mux_uart_pkg::*;

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = AW + 1;

   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr_q];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mux_uart.sv
// Bus-attached 8N1 UART with status/data registers and TX/RX FIFOs.
// Define MUX_UART_IRQ_EN to add the interrupt enable register at BASE_ADDR+2.
module mux_uart
#(
   parameter logic [18:0] BASE_ADDR    = 19'h3f200,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [18:0] address,
   input  logic        write_en,
   input  logic        read_en,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   input  logic        rx,
   output logic        tx,
   output logic        int_reqn,
   output logic [3:0]  irq_number
);
   import mux_uart_pkg::*;

   localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

   logic sel_status, sel_data;
   assign sel_status = (address == BASE_ADDR + 19'(OffStatus));
   assign sel_data   = (address == BASE_ADDR + 19'(OffData));

   logic       tx_full, tx_empty, tx_pop;
   logic       rx_full, rx_empty, rx_pop, rx_push;
   logic [7:0] tx_head, rx_head;

   assign rx_pop = read_en & sel_data & ~rx_empty;

   mux_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (write_en & sel_data),
      .pop   (tx_pop),
      .din   (data_in),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   logic [7:0] rx_shift_q, rx_shift_d;

   mux_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_shift_q),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // Transmitter
   tx_state_e       tx_state_q, tx_state_d;
   logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]      tx_bit_q, tx_bit_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            tx_q, tx_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         TxIdle: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_cnt_d   = '0;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            if (tx_cnt_q == LastCnt) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TxData;
            end else begin
               tx_cnt_d = tx_cnt_q + CntW'(1);
            end
         end
         TxData: begin
            if (tx_cnt_q == LastCnt) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TxStop;
               end else begin
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_bit_d   = tx_bit_q + 3'd1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CntW'(1);
            end
         end
         TxStop: begin
            if (tx_cnt_q == LastCnt) begin
               tx_cnt_d = '0;
               // Chain straight into the next start bit when more data is queued
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_shift_d = tx_head;
                  tx_state_d = TxStart;
               end else begin
                  tx_state_d = TxIdle;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CntW'(1);
            end
         end
         default: tx_state_d = TxIdle;
      endcase

      case (tx_state_d)
         TxStart: tx_d = 1'b0;
         TxData:  tx_d = tx_shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign tx = tx_q;

   // Receiver
   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [1:0]      rx_sync_q;
   logic            rx_prev_q, rx_s, fe_set;

   assign rx_s = rx_sync_q[1];

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push    = 1'b0;
      fe_set     = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            // The edge is already one cycle old when seen, so the count starts at 1
            if (rx_prev_q && !rx_s) begin
               rx_cnt_d   = CntW'(1);
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            if (rx_cnt_q == HalfCnt) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s ? RxIdle : RxData;
            end else begin
               rx_cnt_d = rx_cnt_q + CntW'(1);
            end
         end
         RxData: begin
            if (rx_cnt_q == LastCnt) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RxStop;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + CntW'(1);
            end
         end
         RxStop: begin
            if (rx_cnt_q == LastCnt) begin
               rx_cnt_d = '0;
               if (rx_s) begin
                  rx_push    = 1'b1;
                  rx_state_d = RxIdle;
               end else begin
                  fe_set     = 1'b1;
                  rx_state_d = RxBreak;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CntW'(1);
            end
         end
         RxBreak: begin
            if (rx_s) rx_state_d = RxIdle;
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // Sticky error flags; a new error wins over a same-cycle clear
   logic ovr_q, fe_q, ovr_d, fe_d, wr_status, ovr_set;
   assign wr_status = write_en & sel_status;
   assign ovr_set   = rx_push & rx_full & ~rx_pop;
   assign ovr_d     = (ovr_q & ~(wr_status & data_in[StOvr])) | ovr_set;
   assign fe_d      = (fe_q & ~(wr_status & data_in[StFe])) | fe_set;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_sync_q  <= 2'b11;
         rx_prev_q  <= 1'b1;
         ovr_q      <= 1'b0;
         fe_q       <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_sync_q  <= {rx_sync_q[0], rx};
         rx_prev_q  <= rx_s;
         ovr_q      <= ovr_d;
         fe_q       <= fe_d;
      end
   end

   logic       tx_idle;
   logic [7:0] status;
   assign tx_idle = tx_empty & (tx_state_q == TxIdle);

   always_comb begin
      status           = '0;
      status[StRxRdy]  = ~rx_empty;
      status[StTxRdy]  = ~tx_full;
      status[StOvr]    = ovr_q;
      status[StFe]     = fe_q;
      status[StTxIdle] = tx_idle;
   end

`ifdef MUX_UART_IRQ_EN
   logic       sel_irq;
   logic [2:0] irq_en_q;
   assign sel_irq = (address == BASE_ADDR + 19'(OffIrqEn));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                     irq_en_q <= '0;
      else if (write_en && sel_irq)  irq_en_q <= data_in[2:0];
   end

   assign int_reqn = ~|{irq_en_q[2] & (ovr_q | fe_q), irq_en_q[1] & tx_idle,
                        irq_en_q[0] & ~rx_empty};
`else
   assign int_reqn = 1'b1;
`endif

   always_comb begin
      data_out = '0;
      if (sel_status) data_out = status;
      if (sel_data && !rx_empty) data_out = rx_head;
`ifdef MUX_UART_IRQ_EN
      if (sel_irq) data_out = {5'b0, irq_en_q};
`endif
   end

   assign irq_number = IrqLevel;

endmodule

// File: tb/tb_mux_uart.sv
// Scoreboard bench for mux_uart: bus reads and tx frames are checked by separate monitors.
module tb_mux_uart;
   localparam int unsigned Cpb  = 4;
   localparam logic [18:0] Base = 19'h3f200;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [18:0] address = '0;
   logic        write_en = 1'b0;
   logic        read_en = 1'b0;
   logic [7:0]  data_in = '0;
   logic [7:0]  data_out;
   logic        rx = 1'b1;
   logic        tx;
   logic        int_reqn;
   logic [3:0]  irq_number;

   always #5 clock = ~clock;

   mux_uart #(.BASE_ADDR(Base), .CLKS_PER_BIT(Cpb), .FIFO_DEPTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .address    (address),
      .write_en   (write_en),
      .read_en    (read_en),
      .data_in    (data_in),
      .data_out   (data_out),
      .rx         (rx),
      .tx         (tx),
      .int_reqn   (int_reqn),
      .irq_number (irq_number)
   );

   int         n_checks = 0;
   int         n_fail = 0;
   int         tx_frames = 0;
   logic       mon_sample = 1'b0;
   logic       tx_discard = 1'b0;
   logic [7:0] rd_exp_q[$];
   string      rd_name_q[$];
   logic [7:0] tx_exp_q[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Bus read monitor
   always @(negedge clock) begin
      if (mon_sample) begin
         if (rd_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_unexpected: got %h, expected no read", data_out);
         end else begin
            check(rd_name_q.pop_front(), data_out, rd_exp_q.pop_front());
         end
      end
   end

   // Serial-line monitor on tx
   initial begin : tx_mon
      logic [7:0] b;
      logic       stop_bit;
      forever begin
         @(negedge tx);
         repeat (Cpb / 2) @(negedge clock);
         for (int i = 0; i < 8; i++) begin
            repeat (Cpb) @(negedge clock);
            b[i] = tx;
         end
         repeat (Cpb) @(negedge clock);
         stop_bit = tx;
         if (tx_discard) begin
            tx_discard = 1'b0;
         end else begin
            tx_frames++;
            check("tx_stop_bit", {7'b0, stop_bit}, 8'h01);
            if (tx_exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL tx_unexpected: got frame %h, expected none", b);
            end else begin
               check("tx_frame", b, tx_exp_q.pop_front());
            end
         end
      end
   end

   task automatic bus_read(input logic [18:0] a, input logic pop, input logic [7:0] exp,
                           input string name);
      @(posedge clock); #1;
      address = a;
      read_en = pop;
      rd_exp_q.push_back(exp);
      rd_name_q.push_back(name);
      mon_sample = 1'b1;
      @(posedge clock); #1;
      read_en = 1'b0;
      mon_sample = 1'b0;
      address = '0;
   endtask

   task automatic bus_write(input logic [18:0] a, input logic [7:0] d);
      @(posedge clock); #1;
      address = a;
      data_in = d;
      write_en = 1'b1;
      @(posedge clock); #1;
      write_en = 1'b0;
      address = '0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      @(posedge clock); #1;
      rx = 1'b0;
      repeat (Cpb) @(posedge clock); #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Cpb) @(posedge clock); #1;
      end
      rx = stop;
      repeat (Cpb) @(posedge clock); #1;
      rx = 1'b1;
   endtask

   task automatic wait_txidle(input int bound);
      int n = 0;
      address = Base;
      @(negedge clock);
      while (data_out[4] !== 1'b1 && n < bound) begin
         @(negedge clock);
         n++;
      end
      check("txidle_wait", {7'b0, data_out[4]}, 8'h01);
      address = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   logic [7:0] burst [6];

   initial begin
      burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      // Reset state
      repeat (3) @(posedge clock); #1;
      check("reset_tx", {7'b0, tx}, 8'h01);
      check("reset_int_reqn", {7'b0, int_reqn}, 8'h01);
      check("irq_number", {4'b0, irq_number}, 8'h06);
      reset = 1'b0;
      bus_read(Base, 1'b0, 8'h12, "status_idle");
      bus_read(Base + 19'd5, 1'b0, 8'h00, "undecoded_addr");
      bus_read(Base + 19'd2, 1'b0, 8'h00, "irq_en_reset");
      bus_read(Base + 19'd1, 1'b1, 8'h00, "data_empty");

      // Single byte: frame is checked by the tx monitor; TXIDLE after 40 clocks
      tx_exp_q.push_back(8'h48);
      bus_write(Base + 19'd1, 8'h48);
      bus_read(Base, 1'b0, 8'h02, "status_tx_busy");
      address = Base;
      repeat (39) @(negedge clock);
      check("txidle_at_39", {7'b0, data_out[4]}, 8'h00);
      @(negedge clock);
      check("txidle_at_40", {7'b0, data_out[4]}, 8'h01);
      address = '0;

      // Six back-to-back writes: the sixth is dropped
      tx_frames = 0;
      for (int i = 0; i < 5; i++) tx_exp_q.push_back(burst[i]);
      @(posedge clock); #1;
      address = Base + 19'd1;
      write_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data_in = burst[i];
         @(posedge clock); #1;
      end
      write_en = 1'b0;
      address = '0;
      bus_read(Base, 1'b0, 8'h00, "status_tx_full");
      wait_txidle(400);
      check("tx_frame_count", 8'(tx_frames), 8'd5);
      bus_read(Base, 1'b0, 8'h12, "status_after_burst");

      // Receive one byte
      send_rx(8'h5A, 1'b1);
      repeat (2) @(posedge clock);
      bus_read(Base, 1'b0, 8'h13, "status_rxrdy");
      bus_read(Base + 19'd1, 1'b1, 8'h5A, "rx_data_5a");
      bus_read(Base, 1'b0, 8'h12, "status_after_pop");

      // Framing error and its W1C
      send_rx(8'hC3, 1'b0);
      repeat (4) @(posedge clock);
      bus_read(Base, 1'b0, 8'h1A, "status_fe");
      bus_write(Base, 8'h08);
      bus_read(Base, 1'b0, 8'h12, "status_fe_cleared");

      // Overrun keeps the four oldest bytes
      send_rx(8'hA1, 1'b1);
      send_rx(8'hB2, 1'b1);
      send_rx(8'hC3, 1'b1);
      send_rx(8'hD4, 1'b1);
      send_rx(8'hE5, 1'b1);
      repeat (2) @(posedge clock);
      bus_read(Base, 1'b0, 8'h17, "status_ovr");
      bus_read(Base + 19'd1, 1'b1, 8'hA1, "rx_order_0");
      bus_read(Base + 19'd1, 1'b1, 8'hB2, "rx_order_1");
      bus_read(Base + 19'd1, 1'b1, 8'hC3, "rx_order_2");
      bus_read(Base + 19'd1, 1'b1, 8'hD4, "rx_order_3");
      bus_read(Base, 1'b0, 8'h16, "status_ovr_sticky");
      bus_write(Base, 8'h04);
      bus_read(Base, 1'b0, 8'h12, "status_ovr_cleared");

      // Reset mid-frame on both directions
      send_rx(8'h77, 1'b1);
      repeat (2) @(posedge clock);
      tx_discard = 1'b1;
      bus_write(Base + 19'd1, 8'h00);
      repeat (10) @(posedge clock); #1;
      check("tx_mid_frame", {7'b0, tx}, 8'h00);
      rx = 1'b0;
      repeat (3) @(posedge clock); #1;
      reset = 1'b1;
      #1;
      check("tx_async_reset", {7'b0, tx}, 8'h01);
      @(posedge clock); #1;
      rx = 1'b1;
      reset = 1'b0;
      bus_read(Base, 1'b0, 8'h12, "status_after_reset");
      bus_read(Base + 19'd1, 1'b1, 8'h00, "data_after_reset");
      repeat (50) @(posedge clock);

      check("tx_frames_pending", 8'(tx_exp_q.size()), 8'd0);
      check("reads_pending", 8'(rd_exp_q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_uart.md
Name: mux_uart

Overview:
- Bus-attached serial port that replaces the CPU6 bench's pretend UART at the MUX 0 addresses.
- Sits on the CPU6 address/data bus beside Memory.
- Provides a status register and a data register, with TX and RX FIFOs and 8N1 serial framing.
- The bench's console printing moves to a serial-line monitor on the tx pin.

Parameters:
- BASE_ADDR, 19'h3f200, status register address; data register is BASE_ADDR+1.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be at least 4 and even.
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; must be a power of 2.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- address  input  19  CPU6 address bus.
- write_en  input  1  CPU6 bus write strobe, one cycle per write.
- read_en  input  1  one-cycle read strobe from bus glue; pops RX only when the data register is selected.
- data_in  input  8  CPU write data.
- data_out  output  8  read data; combinational; 8'h00 when neither register is selected.
- rx  input  1  serial in; asynchronous; idle high.
- tx  output  1  serial out; idle high.
- int_reqn  output  1  active-low interrupt request.
- irq_number  output  4  interrupt level, constant 4'd6.

Behaviour:
- Reset state:
  - tx=1, int_reqn=1.
  - Both FIFOs empty; all sticky flags 0.
  - TX and RX state machines IDLE.
- Status register read layout:
  - bit0 RXRDY: RX FIFO not empty.
  - bit1 TXRDY: TX FIFO not full.
  - bit2 OVR: sticky RX overrun.
  - bit3 FE: sticky framing error.
  - bit4 TXIDLE: TX FIFO empty and TX state machine IDLE.
  - bits7:5 read 0.
  - An idle, empty port therefore reads 8'h12.
- Status register write: write-1-to-clear for bits 2 and 3; other bits ignored.
- Data register write:
  - Pushes data_in into the TX FIFO.
  - If the FIFO is full, the byte is dropped silently.
- Data register read:
  - data_out shows the RX FIFO head.
  - On read_en, the head is popped.
  - If the FIFO is empty, data_out is 8'h00 and there is no pop.
- TX state machine: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state or bit lasts CLKS_PER_BIT cycles.
  - IDLE with a non-empty FIFO pops the head and drives tx=0 on the next cycle.
  - Back-to-back bytes have no extra idle bit.
- RX synchronizer and data path:
  - rx passes through a 2-flop synchronizer.
  - A falling edge in IDLE enters START.
  - The line is sampled at CLKS_PER_BIT/2; if it is high, this is a false start and the state machine returns to IDLE.
  - DATA samples each bit at its midpoint.
- RX stop bit:
  - STOP samples at mid-bit.
  - If the sample is 1, the byte is pushed to the RX FIFO.
  - If the sample is 0, FE is set, the byte is discarded, and the state machine returns to IDLE once rx is high.
- RX overflow and ordering:
  - Receiving into a full RX FIFO drops the new byte and sets OVR; existing contents are kept.
- Simultaneous events:
  - A push and a pop in the same cycle on the same FIFO are both honoured; count is unchanged.
  - When the FIFO is full, the pop happens first, so the push succeeds.
  - A W1C write and a new error in the same cycle leave the flag set.
- Reset mid-frame:
  - tx returns to 1 immediately (asynchronous).
  - Any partial RX byte is discarded.
- FIFO pointers wrap modulo FIFO_DEPTH; an extra count bit distinguishes full from empty.

Optional Feature:
- Macro: MUX_UART_IRQ_EN.
- Defined:
  - Enable register at BASE_ADDR+2: bit0 enables RXRDY, bit1 enables TXIDLE, bit2 enables errors; reset value 0.
  - int_reqn = ~|(enabled conditions); a level, cleared by servicing the cause.
  - BASE_ADDR+2 reads back the enable register.
- Undefined:
  - int_reqn tied to 1.
  - BASE_ADDR+2 is not decoded; data_out reads 8'h00 there.

Decomposition:
- Package mux_uart_pkg holds:
  - Status bit index constants.
  - Register offset constants (0, 1, 2).
  - IRQ level constant 4'd6.
- One sub-module, mux_uart_fifo, instanced twice:
  - Parameter DEPTH; 8-bit width.
  - Ports: push, pop, din, dout, full, empty.

Test Plan:
- Reset, then read BASE_ADDR -> data_out=8'h12, tx=1; read BASE_ADDR+5 -> 8'h00.
- CLKS_PER_BIT=4, write 8'h48 to 3f201 -> tx low for 4 clocks, then bits 0,0,0,1,0,0,1,0 at 4 clocks each, then high; TXIDLE returns to 1 after 40 clocks.
- Write 6 bytes back-to-back -> the first is popped into the shifter; the TX FIFO then fills; TXRDY=0; the 6th byte is dropped; exactly 5 frames appear on tx.
- Drive an 8'h5A frame on rx -> RXRDY=1; data read with read_en returns 8'h5A; status then reads 8'h12.
- Frame with stop bit 0 -> FE=1, RX FIFO empty; write 8'h08 to status -> FE=0.
- Receive 5 bytes without reading -> OVR=1; the 4 earliest bytes read back in order; assert reset mid-frame -> FIFO empty and tx=1 immediately.
